// File: rtl/mem_arbiter_pkg.sv
// Shared LC-3b types used by the memory arbiter: word/line widths and the
// arbiter's state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    arb_idle,
    arb_serve_i,
    arb_serve_d
  } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the icache and
// dcache; the granted request is latched and drives pmem until pmem_resp.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  lc3b_arb_state state, state_next;
  logic          last_grant;
  logic          op_read, op_write;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic          d_req, grant_i, grant_d;

  always_comb begin
    state_next = state;
    d_req      = d_read | d_write;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    unique case (state)
      arb_idle: begin
        // On contention the side that did not win last time is granted.
        if (d_req && (!i_read || !last_grant)) begin
          grant_d    = 1'b1;
          state_next = arb_serve_d;
        end else if (i_read) begin
          grant_i    = 1'b1;
          state_next = arb_serve_i;
        end
      end
      arb_serve_i: begin
        if (pmem_resp) begin
          i_resp     = 1'b1;
          i_rdata    = pmem_rdata;
          state_next = arb_idle;
        end
      end
      arb_serve_d: begin
        if (pmem_resp) begin
          d_resp     = 1'b1;
          d_rdata    = pmem_rdata;
          state_next = arb_idle;
        end
      end
      default: state_next = arb_idle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= arb_idle;
      last_grant <= 1'b0;
      op_read    <= 1'b0;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_next;
      if (grant_d) begin
        // Read and write together is treated as a writeback.
        last_grant <= 1'b1;
        op_write   <= d_write;
        op_read    <= d_read & ~d_write;
        addr_q     <= d_address;
        wdata_q    <= d_wdata;
      end else if (grant_i) begin
        last_grant <= 1'b0;
        op_read    <= 1'b1;
        op_write   <= 1'b0;
        addr_q     <= i_address;
        wdata_q    <= '0;
      end else if (state != arb_idle && pmem_resp) begin
        op_read    <= 1'b0;
        op_write   <= 1'b0;
      end
    end
  end

  // Strobes come straight from flops, so they are glitch-free and drop
  // asynchronously with reset.
  assign pmem_read    = op_read;
  assign pmem_write   = op_write;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// requesters and memory, compared against a transaction-level model.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_read, d_read, d_write, pmem_resp;
  logic [15:0]  i_address, d_address;
  logic [127:0] d_wdata, pmem_rdata;
  logic [127:0] i_rdata, d_rdata, pmem_wdata;
  logic         i_resp, d_resp, pmem_read, pmem_write;
  logic [15:0]  pmem_address;

  int checks = 0;
  int failures = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the transaction currently owning the memory port.
  typedef struct {
    bit           side;   // 0 = icache, 1 = dcache
    bit           rd;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  txn_t cur;
  bit   cur_valid = 1'b0;
  bit   m_last = 1'b0;
  bit   want_d, want_i, take_d;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_valid = 1'b0;
      m_last    = 1'b0;
    end else if (cur_valid) begin
      if (pmem_resp) cur_valid = 1'b0;
    end else begin
      want_d = d_read || d_write;
      want_i = i_read;
      if (want_d && want_i) take_d = (m_last == 1'b0);
      else                  take_d = want_d;
      if (want_d || want_i) begin
        cur_valid = 1'b1;
        m_last    = take_d;
        cur.side  = take_d;
        if (take_d) begin
          cur.wr    = d_write;
          cur.rd    = d_read && !d_write;
          cur.addr  = d_address;
          cur.wdata = d_wdata;
        end else begin
          cur.wr    = 1'b0;
          cur.rd    = 1'b1;
          cur.addr  = i_address;
          cur.wdata = '0;
        end
      end
    end
  end

  bit exp_i, exp_d;
  always @(negedge clk) begin
    if (!reset) begin
      exp_i = cur_valid && !cur.side && pmem_resp;
      exp_d = cur_valid && cur.side && pmem_resp;
      check_eq("m_pmem_read", pmem_read, cur_valid && cur.rd);
      check_eq("m_pmem_write", pmem_write, cur_valid && cur.wr);
      if (cur_valid) begin
        check_eq("m_pmem_address", pmem_address, cur.addr);
        check_eq("m_pmem_wdata", pmem_wdata, cur.wdata);
      end
      check_eq("m_i_resp", i_resp, exp_i);
      check_eq("m_d_resp", d_resp, exp_d);
      check_eq("m_i_rdata", i_rdata, exp_i ? pmem_rdata : 128'h0);
      check_eq("m_d_rdata", d_rdata, exp_d ? pmem_rdata : 128'h0);
    end
  end

  logic [15:0] t3_exp [3];
  bit i_seen, d_seen;
  int n;
  int op;

  initial begin
    reset = 1'b1;
    i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    repeat (3) tick;
    check_eq("rst_pmem_read", pmem_read, 1'b0);
    check_eq("rst_pmem_write", pmem_write, 1'b0);
    check_eq("rst_pmem_address", pmem_address, 16'h0);
    check_eq("rst_pmem_wdata", pmem_wdata, 128'h0);
    check_eq("rst_i_resp", i_resp, 1'b0);
    check_eq("rst_d_resp", d_resp, 1'b0);
    check_eq("rst_i_rdata", i_rdata, 128'h0);
    check_eq("rst_d_rdata", d_rdata, 128'h0);
    reset = 1'b0;
    tick;

    // icache read
    i_address = 16'h1230; i_read = 1;
    tick;
    check_eq("t1_strobe", pmem_read, 1'b1);
    check_eq("t1_address", pmem_address, 16'h1230);
    tick; tick;
    pmem_rdata = {16{8'hAA}}; pmem_resp = 1;
    #1;
    check_eq("t1_i_resp", i_resp, 1'b1);
    check_eq("t1_i_rdata", i_rdata, {16{8'hAA}});
    check_eq("t1_d_resp", d_resp, 1'b0);
    tick;
    pmem_resp = 0; i_read = 0;
    #1;
    check_eq("t1_once", i_resp, 1'b0);
    tick;

    // dcache writeback with address changing mid-transaction
    d_address = 16'h4000; d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF; d_write = 1;
    tick;
    check_eq("t2_write", pmem_write, 1'b1);
    check_eq("t2_address", pmem_address, 16'h4000);
    check_eq("t2_wdata", pmem_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    d_address = 16'h5000;
    tick;
    check_eq("t2_hold", pmem_address, 16'h4000);
    tick;
    pmem_resp = 1;
    #1;
    check_eq("t2_d_resp", d_resp, 1'b1);
    check_eq("t2_i_resp", i_resp, 1'b0);
    tick;
    pmem_resp = 0; d_write = 0;
    #1;
    check_eq("t2_once", d_resp, 1'b0);
    tick;

    // pmem_resp while idle
    pmem_resp = 1;
    #1;
    check_eq("t4_i_resp", i_resp, 1'b0);
    check_eq("t4_d_resp", d_resp, 1'b0);
    tick;
    pmem_resp = 0;
    check_eq("t4_idle_read", pmem_read, 1'b0);
    check_eq("t4_idle_write", pmem_write, 1'b0);
    tick;

    // read+write together counts as a write
    d_address = 16'h0010; d_read = 1; d_write = 1;
    tick;
    check_eq("t6_write", pmem_write, 1'b1);
    check_eq("t6_read", pmem_read, 1'b0);
    check_eq("t6_address", pmem_address, 16'h0010);
    tick;
    pmem_resp = 1;
    tick;
    pmem_resp = 0; d_read = 0; d_write = 0;
    tick;

    // both requesters held from reset: order D, I, D
    reset = 1;
    i_address = 16'h0100; d_address = 16'h0200; i_read = 1; d_read = 1;
    tick;
    reset = 0;
    t3_exp[0] = 16'h0200; t3_exp[1] = 16'h0100; t3_exp[2] = 16'h0200;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!(pmem_read || pmem_write) && n < 10) begin
        tick;
        n++;
      end
      check_eq("t3_order", pmem_address, t3_exp[k]);
      tick;
      pmem_resp = 1; pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check_eq("t3_resp", (k == 1) ? i_resp : d_resp, 1'b1);
      tick;
      pmem_resp = 0;
      if (k == 2) begin
        i_read = 0; d_read = 0;
      end
      #1;
      check_eq("t3_gap", pmem_read, 1'b0);
    end
    tick;

    // reset in the middle of a dcache read
    d_address = 16'h0300; d_read = 1;
    tick;
    tick;
    #2;
    reset = 1;
    #1;
    check_eq("t5_async_drop", pmem_read, 1'b0);
    d_read = 0;
    tick; tick;
    reset = 0;
    #1;
    pmem_resp = 1;
    #1;
    check_eq("t5_no_d_resp", d_resp, 1'b0);
    tick;
    pmem_resp = 0;
    check_eq("t5_idle", pmem_read, 1'b0);
    tick;

    // randomized requesters and memory
    i_seen = 0; d_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (pmem_read || pmem_write) pmem_resp = ($urandom_range(0, 2) == 0);
      else                         pmem_resp = ($urandom_range(0, 7) == 0);
      if (i_seen) i_read = 0;
      else if (!i_read && $urandom_range(0, 3) == 0) begin
        i_read = 1; i_address = 16'($urandom);
      end else if (i_read && $urandom_range(0, 15) == 0) i_address = 16'($urandom);
      if (d_seen) begin
        d_read = 0; d_write = 0;
      end else if (!d_read && !d_write && $urandom_range(0, 3) == 0) begin
        op = $urandom_range(0, 4);
        d_read  = (op <= 1) || (op == 4);
        d_write = (op == 2) || (op == 3) || (op == 4);
        d_address = 16'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end else if ((d_read || d_write) && $urandom_range(0, 7) == 0) begin
        d_address = 16'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      i_seen = i_resp;
      d_seen = d_resp;
      tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
